// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_arbiter
//  Description : Round-robin arbiter that shares the single A port of one
//                alta_bram9k among N_REQ single-beat requesters. The granted
//                request is steered combinationally onto the BRAM pins. In-
//                flight reads are tracked so that the returned data is tagged
//                with a one-hot per-requester rvalid strobe.
//  Ports       : clk          - system clock, also the BRAM Clk0
//                rst          - synchronous active-high reset
//                req_i        - per-requester access request
//                we_i         - per-requester write qualifier (1 = write)
//                addr_i       - packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//                wdata_i      - packed write data, packed the same way
//                gnt_o        - one-hot grant, combinational
//                rvalid_o     - one-hot read-return strobe
//                rdata_o      - shared read data, qualified by rvalid_o
//                bram_addr_o  - BRAM AddressA
//                bram_din_o   - BRAM DataInA
//                bram_we_o    - BRAM WeA
//                bram_re_o    - BRAM ReA
//                bram_clken_o - BRAM ClkEn0
//                bram_dout_i  - BRAM DataOutA
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           we_i,
    input  logic [N_REQ*ADDR_W-1:0]    addr_i,
    input  logic [N_REQ*DATA_W-1:0]    wdata_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [N_REQ-1:0]           rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [ADDR_W-1:0]          bram_addr_o,
    output logic [DATA_W-1:0]          bram_din_o,
    output logic                       bram_we_o,
    output logic                       bram_re_o,
    output logic                       bram_clken_o,
    input  logic [DATA_W-1:0]          bram_dout_i
);

    localparam int             PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic [PTR_W-1:0]  sel;
    logic [PTR_W:0]    idx;
    logic [N_REQ-1:0]  gnt;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] last_addr_q;

    // Read-tracking pipeline: a valid bit and a one-hot requester id per stage
    logic [RD_LAT-1:0] vld_q;
    logic [N_REQ-1:0]  id_q [RD_LAT];

    // Search starts at ptr and wraps modulo N_REQ. idx carries one extra bit
    // so that ptr+j never overflows before the explicit wrap subtraction,
    // which keeps non-power-of-two N_REQ correct.
    always_comb begin
        gnt    = '0;
        sel    = '0;
        accept = 1'b0;
        idx    = '0;
        for (int j = 0; j < N_REQ; j++) begin
            idx = {1'b0, ptr_q} + (PTR_W+1)'(j);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (!accept && !rst && req_i[idx[PTR_W-1:0]]) begin
                accept                 = 1'b1;
                gnt[idx[PTR_W-1:0]]    = 1'b1;
                sel                    = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_we    = we_i[sel];
        sel_addr  = addr_i[sel*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[sel*DATA_W +: DATA_W];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (sel == PTR_LAST) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            last_addr_q <= '0;
            vld_q       <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                last_addr_q <= sel_addr;
            end
            vld_q[0] <= accept & ~sel_we;
            id_q[0]  <= gnt;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                id_q[s]  <= id_q[s-1];
            end
        end
    end

    assign gnt_o        = gnt;
    assign rvalid_o     = vld_q[RD_LAT-1] ? id_q[RD_LAT-1] : '0;
    assign rdata_o      = bram_dout_i;

    // Idle cycles keep the last address on the pins so the BRAM address
    // input does not toggle needlessly.
    assign bram_addr_o  = accept ? sel_addr : last_addr_q;
    assign bram_din_o   = accept ? sel_wdata : '0;
    assign bram_we_o    = accept & sel_we;
    assign bram_re_o    = accept & ~sel_we;
    assign bram_clken_o = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_port_arbiter
//  Description : Directed self-checking bench for bram_port_arbiter. Four
//                instances cover N_REQ=4/RD_LAT=1, N_REQ=3, RD_LAT=2 and
//                RD_LAT=3, each with a small behavioural BRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ROM contents seen by all BRAM models
    function automatic logic [7:0] rom(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: N_REQ=4, RD_LAT=1 ----------------
    logic [3:0]  a_req, a_we, a_gnt, a_rvalid;
    logic [47:0] a_addr;
    logic [31:0] a_wdata;
    logic [7:0]  a_rdata, a_din, a_dout;
    logic [11:0] a_baddr;
    logic        a_bwe, a_bre, a_bclken;
    logic [11:0] a_wr_addr;
    logic [7:0]  a_wr_val;
    logic        a_wr_vld = 1'b0;

    bram_port_arbiter #(.N_REQ(4), .ADDR_W(12), .DATA_W(8), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
        .wdata_i(a_wdata), .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata),
        .bram_addr_o(a_baddr), .bram_din_o(a_din), .bram_we_o(a_bwe),
        .bram_re_o(a_bre), .bram_clken_o(a_bclken), .bram_dout_i(a_dout)
    );

    // ROM backed memory with a single write-override entry
    always @(posedge clk) begin
        if (a_bclken && a_bre)
            a_dout <= (a_wr_vld && a_wr_addr == a_baddr) ? a_wr_val : rom(a_baddr);
        if (a_bclken && a_bwe) begin
            a_wr_vld  <= 1'b1;
            a_wr_addr <= a_baddr;
            a_wr_val  <= a_din;
        end
    end

    // ---------------- instance B: N_REQ=3, RD_LAT=1 ----------------
    logic [2:0]  b_req, b_we, b_gnt, b_rvalid;
    logic [35:0] b_addr;
    logic [23:0] b_wdata;
    logic [7:0]  b_rdata, b_din;
    logic [11:0] b_baddr;
    logic        b_bwe, b_bre, b_bclken;

    bram_port_arbiter #(.N_REQ(3), .ADDR_W(12), .DATA_W(8), .RD_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
        .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
        .bram_addr_o(b_baddr), .bram_din_o(b_din), .bram_we_o(b_bwe),
        .bram_re_o(b_bre), .bram_clken_o(b_bclken), .bram_dout_i(8'h00)
    );

    // ---------------- instance C: N_REQ=4, RD_LAT=2 ----------------
    logic [3:0]  c_req, c_we, c_gnt, c_rvalid;
    logic [47:0] c_addr;
    logic [31:0] c_wdata;
    logic [7:0]  c_rdata, c_din, c_d1, c_d2;
    logic [11:0] c_baddr;
    logic        c_bwe, c_bre, c_bclken;

    bram_port_arbiter #(.N_REQ(4), .ADDR_W(12), .DATA_W(8), .RD_LAT(2)) u_dut_c (
        .clk(clk), .rst(rst), .req_i(c_req), .we_i(c_we), .addr_i(c_addr),
        .wdata_i(c_wdata), .gnt_o(c_gnt), .rvalid_o(c_rvalid), .rdata_o(c_rdata),
        .bram_addr_o(c_baddr), .bram_din_o(c_din), .bram_we_o(c_bwe),
        .bram_re_o(c_bre), .bram_clken_o(c_bclken), .bram_dout_i(c_d2)
    );

    always @(posedge clk) begin
        if (c_bclken && c_bre) c_d1 <= rom(c_baddr);
        c_d2 <= c_d1;
    end

    // ---------------- instance D: N_REQ=4, RD_LAT=3 ----------------
    logic [3:0]  d_req, d_we, d_gnt, d_rvalid;
    logic [47:0] d_addr;
    logic [31:0] d_wdata;
    logic [7:0]  d_rdata, d_din, d_d1, d_d2, d_d3;
    logic [11:0] d_baddr;
    logic        d_bwe, d_bre, d_bclken;

    bram_port_arbiter #(.N_REQ(4), .ADDR_W(12), .DATA_W(8), .RD_LAT(3)) u_dut_d (
        .clk(clk), .rst(rst), .req_i(d_req), .we_i(d_we), .addr_i(d_addr),
        .wdata_i(d_wdata), .gnt_o(d_gnt), .rvalid_o(d_rvalid), .rdata_o(d_rdata),
        .bram_addr_o(d_baddr), .bram_din_o(d_din), .bram_we_o(d_bwe),
        .bram_re_o(d_bre), .bram_clken_o(d_bclken), .bram_dout_i(d_d3)
    );

    always @(posedge clk) begin
        if (d_bclken && d_bre) d_d1 <= rom(d_baddr);
        d_d2 <= d_d1;
        d_d3 <= d_d2;
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [3:0] rr_seq [5];

    initial begin
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        a_req = 4'hF; a_we = 4'hF;
        a_addr = {12'h030, 12'h020, 12'h010, 12'h000};
        a_wdata = 32'h11223344;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
        d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0;

        // ---- reset with every request (and write) asserted ----
        repeat (2) begin
            tick();
            check("rst_gnt", a_gnt, 4'b0000);
            check("rst_we", a_bwe, 1'b0);
            check("rst_re", a_bre, 1'b0);
            check("rst_rvalid", a_rvalid, 4'b0000);
        end

        // ---- round-robin rotation, all reads ----
        rst = 1'b0;
        a_we = 4'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_gnt", a_gnt, rr_seq[i]);
            check("rr_addr", a_baddr, 12'h010 * (i % 4));
            check("rr_re", a_bre, 1'b1);
            check("rr_clken", a_bclken, 1'b1);
            tick();
            check("rr_rvalid", a_rvalid, rr_seq[i]);
            check("rr_rdata", a_rdata, rom(12'h010 * (i % 4)));
        end

        // ---- write then read-back ----
        a_req = 4'b0100; a_we = 4'b0100;
        a_addr[24 +: 12] = 12'h3F0; a_wdata[16 +: 8] = 8'hA5;
        #1;
        check("wr_gnt", a_gnt, 4'b0100);
        check("wr_we", a_bwe, 1'b1);
        check("wr_re", a_bre, 1'b0);
        check("wr_addr", a_baddr, 12'h3F0);
        check("wr_din", a_din, 8'hA5);
        tick();
        check("wr_rvalid", a_rvalid, 4'b0000);
        a_req = 4'b0001; a_we = 4'b0000; a_addr[0 +: 12] = 12'h3F0;
        #1;
        check("rb_gnt", a_gnt, 4'b0001);
        check("rb_re", a_bre, 1'b1);
        tick();
        check("rb_rvalid", a_rvalid, 4'b0001);
        check("rb_rdata", a_rdata, 8'hA5);
        a_req = 4'b0000;
        #1;
        check("idle_gnt", a_gnt, 4'b0000);
        check("idle_we", a_bwe, 1'b0);
        check("idle_re", a_bre, 1'b0);
        check("idle_clken", a_bclken, 1'b1);
        check("idle_addr", a_baddr, 12'h3F0);
        check("idle_din", a_din, 8'h00);
        tick();
        check("idle_rvalid", a_rvalid, 4'b0000);

        // Reset-time writes must not have landed at address 0
        a_req = 4'b0001; a_addr[0 +: 12] = 12'h000;
        tick();
        a_req = 4'b0000;
        check("rst_nowrite", a_rdata, rom(12'h000));

        // ---- N_REQ=3 pointer wrap and skip ----
        b_req = 3'b100;
        #1;
        check("b_gnt_setup", b_gnt, 3'b100);
        tick();
        b_req = 3'b110;
        #1;
        check("b_gnt_wrap", b_gnt, 3'b010);
        tick();
        check("b_gnt_next", b_gnt, 3'b100);
        tick();
        check("b_gnt_wrap2", b_gnt, 3'b010);
        b_req = 3'b000;

        // ---- RD_LAT=2 back-to-back reads, requesters 1 then 3 ----
        c_addr[12 +: 12] = 12'h111; c_addr[36 +: 12] = 12'h333;
        c_req = 4'b0010;
        #1;
        check("c_gnt1", c_gnt, 4'b0010);
        tick();
        c_req = 4'b1000;
        #1;
        check("c_gnt3", c_gnt, 4'b1000);
        check("c_early", c_rvalid, 4'b0000);
        tick();
        c_req = 4'b0000;
        check("c_rvalid1", c_rvalid, 4'b0010);
        check("c_rdata1", c_rdata, rom(12'h111));
        tick();
        check("c_rvalid3", c_rvalid, 4'b1000);
        check("c_rdata3", c_rdata, rom(12'h333));
        tick();
        check("c_rvalid_end", c_rvalid, 4'b0000);

        // ---- RD_LAT=3 normal read ----
        d_addr[0 +: 12] = 12'h0AB; d_addr[12 +: 12] = 12'h0CD;
        d_req = 4'b0001;
        #1;
        check("d_gnt0", d_gnt, 4'b0001);
        tick();
        d_req = 4'b0000;
        check("d_lat1", d_rvalid, 4'b0000);
        tick();
        check("d_lat2", d_rvalid, 4'b0000);
        tick();
        check("d_rvalid", d_rvalid, 4'b0001);
        check("d_rdata", d_rdata, rom(12'h0AB));
        tick();
        check("d_rvalid_end", d_rvalid, 4'b0000);

        // ---- RD_LAT=3 read dropped by reset ----
        d_req = 4'b0010;
        #1;
        check("d_gnt1", d_gnt, 4'b0010);
        tick();
        d_req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("d_drop", d_rvalid, 4'b0000);
            tick();
        end
        d_req = 4'b1111;
        #1;
        check("d_ptr_reset", d_gnt, 4'b0001);
        d_req = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
